scroll_ctrl: RTL and testbench
==============================

# scroll_ctrl

Sequencing controller for the 4-digit scrolling ID display. Holds the N-nibble text in a rotating register, schedules one-nibble scroll steps on an external slow tick, dwells at the home position after every full revolution, supports pause (with blinking) and direction control. It drives the four digit nibbles and a per-digit blank mask straight into the existing multiplexed display block. It sits between the 2 Hz tick divider and the display scanner.

## Interface
- N_DIGITS, 11: text length in nibbles; legal range 5..16.
- TEXT, 44'haaa32202008: initial text, 4*N_DIGITS bits; nibble 4'hA means space.
- HOLD_STEPS, 4: steps dwelt at home position; legal range 1..15.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- step  in  1  one-cycle scroll tick (2 Hz pulse).
- run_req  in  1  level: 1 = scroll, 0 = pause.
- dir  in  1  0 = text moves left, 1 = text moves right; sampled on each step.
- reload  in  1  one-cycle pulse: restore TEXT and home position.
- d3, d2, d1, d0  out  4 each  displayed nibbles, d3 leftmost.
- blank  out  4  blank[i]=1 blanks digit i.
- state  out  2  FSM state: IDLE=0, HOLD=1, SCROLL=2, PAUSE=3.
- wrap  out  1  one-cycle pulse when a scroll step returns to home.

## Operation
- Text register R (4*N_DIGITS bits); d3..d0 = top four nibbles of R, MSB first.
- Left shift: R <= {R[4N-5:0], R[4N-1:4N-4]}, pos <= (pos+1) mod N. Right shift: R <= {R[3:0], R[4N-1:4]}, pos <= (pos-1) mod N. pos is 4 bits, home = 0.
- blank[i] = 1 when di == 4'hA, or when in PAUSE with blink phase = 1 (then blank = 4'hF).
- IDLE: display frozen at home; run_req=1 -> HOLD with hold count cleared.
- HOLD: each step increments hold count, no shift; count reaching HOLD_STEPS -> SCROLL and count cleared.
- SCROLL: each step shifts once per dir. If the new pos is 0, assert wrap and go to HOLD.
- PAUSE is entered from HOLD or SCROLL when run_req=0. The source state is saved, R, pos and hold count are frozen, and the blink phase is cleared. Each step toggles the blink phase. run_req=1 returns to the saved state, keeps pos and hold count, and clears the blink phase.
- IDLE ignores step.
- Priority in one cycle: reset > reload > run_req=0 > step.
  - A step coinciding with run_req falling in HOLD/SCROLL is dropped: no shift, no count.
- Reload: R <= TEXT, pos <= 0, hold count <= 0, blink phase <= 0. Next state is HOLD if run_req=1, else IDLE. No wrap is asserted.
- Direction change mid-revolution is legal. wrap fires whenever pos returns to 0 through a SCROLL step, in either direction.

## Timing
- All outputs are registered. d*, blank, state and pos update on the clock edge that samples step, so outputs are valid the next cycle (1-cycle latency).
- wrap is high for exactly the one cycle in which d* first shows the home window; state reads HOLD in that same cycle.
- Reset (reset=0 at a clock edge) gives: state=IDLE, R=TEXT, pos=0, hold count=0, blink phase=0, wrap=0.
  - With the defaults: d3..d0 = A,A,A,3 and blank=4'b1110.
  - Reset mid-scroll has the same result on the next edge.
- IDLE->HOLD happens on the first edge with run_req=1; no step is needed.
- A full cycle with run_req held high is HOLD_STEPS + N_DIGITS steps between wrap pulses (15 steps with defaults).

## Test plan
- Reset, then run_req=0 with steps applied -> d3..d0 = A,A,A,3, blank=1110, state=0 held, wrap never asserted.
- run_req=1, dir=0, 4 steps -> state=2. Next step -> d3..d0 = A,A,3,2, blank=1100. After 11 SCROLL steps total -> wrap for 1 cycle, d3..d0 = A,A,A,3, state=1.
- dir=1 from home after HOLD, 1 step -> d3..d0 = 8,A,A,A, blank=0111, pos=10. 10 more steps -> wrap.
- In SCROLL after 3 steps, drop run_req in the same cycle as a step -> no shift, state=3. 2 steps -> blank toggles F then normal. run_req=1 -> state=2, next step gives pos=4.
- reload pulse coincident with a step mid-SCROLL, run_req=1 -> d3..d0 = A,A,A,3, pos=0, state=1, no wrap. Dwell restarts at 0 and needs 4 steps.
- reset asserted while in PAUSE with blink=1 -> next cycle state=0, blank=1110, home window shown.

Source files
------------

// File: rtl/scroll_ctrl_if.sv
// Control and display bundle between the tick/mode logic, scroll_ctrl and the digit scanner.
// pos is exported so the current rotation offset can be observed alongside the digits.
interface scroll_ctrl_if;
    logic       step;
    logic       run_req;
    logic       dir;
    logic       reload;
    logic [3:0] d3;
    logic [3:0] d2;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [3:0] blank;
    logic [1:0] state;
    logic       wrap;
    logic [3:0] pos;

    modport master (
        output step, run_req, dir, reload,
        input  d3, d2, d1, d0, blank, state, wrap, pos
    );

    modport slave (
        input  step, run_req, dir, reload,
        output d3, d2, d1, d0, blank, state, wrap, pos
    );
endinterface

// File: rtl/scroll_ctrl.sv
// Scrolling ID text sequencer: rotates an N-nibble text on slow ticks, dwells at home,
// pauses with blink, and feeds four digit nibbles plus a blank mask to the display scanner.
module scroll_ctrl #(
    parameter int                      N_DIGITS   = 11,
    parameter logic [4*N_DIGITS-1:0]   TEXT       = 44'haaa32202008,
    parameter int                      HOLD_STEPS = 4
) (
    input  logic         clk,
    input  logic         reset,
    scroll_ctrl_if.slave sbus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] SCROLL = 2'd2;
    localparam logic [1:0] PAUSE  = 2'd3;
    localparam int         TW     = 4 * N_DIGITS;

    logic [TW-1:0] r_text;
    logic [3:0]    r_pos;
    logic [3:0]    r_hold;
    logic          r_blink;
    logic [1:0]    r_state;
    logic [1:0]    r_saved;
    logic          r_wrap;

    logic [TW-1:0] w_text_shift;
    logic [3:0]    w_pos_shift;
    logic [15:0]   w_window;

    // Blank a digit showing the space code; a lit blink phase blanks the whole window.
    function automatic logic [3:0] blank_mask(input logic [15:0] win, input logic all_off);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            m[i] = all_off || (win[4*i +: 4] == 4'hA);
        end
        return m;
    endfunction

    always_comb begin
        w_text_shift = r_text;
        w_pos_shift  = r_pos;
        if (sbus.dir) begin
            w_text_shift = {r_text[3:0], r_text[TW-1:4]};
            w_pos_shift  = (r_pos == 4'd0) ? 4'(N_DIGITS - 1) : r_pos - 4'd1;
        end else begin
            w_text_shift = {r_text[TW-5:0], r_text[TW-1 -: 4]};
            w_pos_shift  = (r_pos == 4'(N_DIGITS - 1)) ? 4'd0 : r_pos + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_text  <= TEXT;
            r_pos   <= 4'd0;
            r_hold  <= 4'd0;
            r_blink <= 1'b0;
            r_state <= IDLE;
            r_saved <= HOLD;
            r_wrap  <= 1'b0;
        end else if (sbus.reload) begin
            r_text  <= TEXT;
            r_pos   <= 4'd0;
            r_hold  <= 4'd0;
            r_blink <= 1'b0;
            r_state <= sbus.run_req ? HOLD : IDLE;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (sbus.run_req) begin
                        r_state <= HOLD;
                        r_hold  <= 4'd0;
                    end
                end
                HOLD, SCROLL: begin
                    // Dropping run_req wins over a coincident step, which is discarded.
                    if (!sbus.run_req) begin
                        r_saved <= r_state;
                        r_state <= PAUSE;
                        r_blink <= 1'b0;
                    end else if (sbus.step) begin
                        if (r_state == HOLD) begin
                            if (r_hold + 4'd1 == 4'(HOLD_STEPS)) begin
                                r_state <= SCROLL;
                                r_hold  <= 4'd0;
                            end else begin
                                r_hold <= r_hold + 4'd1;
                            end
                        end else begin
                            r_text <= w_text_shift;
                            r_pos  <= w_pos_shift;
                            if (w_pos_shift == 4'd0) begin
                                r_wrap  <= 1'b1;
                                r_state <= HOLD;
                                r_hold  <= 4'd0;
                            end
                        end
                    end
                end
                default: begin
                    if (sbus.run_req) begin
                        r_state <= r_saved;
                        r_blink <= 1'b0;
                    end else if (sbus.step) begin
                        r_blink <= ~r_blink;
                    end
                end
            endcase
        end
    end

    assign w_window   = r_text[TW-1 -: 16];
    assign sbus.d3    = w_window[15:12];
    assign sbus.d2    = w_window[11:8];
    assign sbus.d1    = w_window[7:4];
    assign sbus.d0    = w_window[3:0];
    assign sbus.blank = blank_mask(w_window, (r_state == PAUSE) && r_blink);
    assign sbus.state = r_state;
    assign sbus.wrap  = r_wrap;
    assign sbus.pos   = r_pos;
endmodule

// File: tb/tb_scroll_ctrl.sv
// Bench for scroll_ctrl: directed stimulus, a position-based reference model checked
// every cycle, and literal expectations at the key points of each scenario.
module tb_scroll_ctrl;
    localparam int              N   = 11;
    localparam int              HS  = 4;
    localparam logic [4*N-1:0]  TXT = 44'haaa32202008;

    logic clk;
    logic reset;
    scroll_ctrl_if bus ();

    scroll_ctrl #(.N_DIGITS(N), .TEXT(TXT), .HOLD_STEPS(HS)) dut (
        .clk   (clk),
        .reset (reset),
        .sbus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference: the text never changes, the window is just the nibbles starting at pos.
    logic [3:0] txt_nib [N];
    int m_pos, m_state, m_hold, m_saved;
    bit m_blink, m_wrap;

    function automatic void chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function automatic logic [3:0] m_dig(int k);
        return txt_nib[(m_pos + k) % N];
    endfunction

    function automatic logic [3:0] m_blank();
        logic [3:0] b;
        for (int k = 0; k < 4; k++) b[3-k] = (m_dig(k) == 4'hA);
        if (m_state == 3 && m_blink) b = 4'hF;
        return b;
    endfunction

    function automatic void model_update();
        if (!reset) begin
            m_pos = 0; m_state = 0; m_hold = 0; m_blink = 0; m_wrap = 0;
        end else if (bus.reload) begin
            m_pos = 0; m_hold = 0; m_blink = 0; m_wrap = 0;
            m_state = bus.run_req ? 1 : 0;
        end else begin
            m_wrap = 0;
            if (m_state == 0) begin
                if (bus.run_req) begin m_state = 1; m_hold = 0; end
            end else if (m_state == 3) begin
                if (bus.run_req) begin m_state = m_saved; m_blink = 0; end
                else if (bus.step) m_blink = !m_blink;
            end else if (!bus.run_req) begin
                m_saved = m_state; m_state = 3; m_blink = 0;
            end else if (bus.step) begin
                if (m_state == 1) begin
                    m_hold++;
                    if (m_hold == HS) begin m_state = 2; m_hold = 0; end
                end else begin
                    m_pos = bus.dir ? (m_pos + N - 1) % N : (m_pos + 1) % N;
                    if (m_pos == 0) begin m_wrap = 1; m_state = 1; m_hold = 0; end
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("d3", bus.d3, m_dig(0));
            chk("d2", bus.d2, m_dig(1));
            chk("d1", bus.d1, m_dig(2));
            chk("d0", bus.d0, m_dig(3));
            chk("blank", bus.blank, m_blank());
            chk("state", bus.state, m_state);
            chk("wrap", bus.wrap, m_wrap);
            chk("pos", bus.pos, m_pos);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        bus.step   = 1'b0;
        bus.reload = 1'b0;
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) begin
            bus.step = 1'b1;
            tick();
        end
    endtask

    function automatic int win();
        return {bus.d3, bus.d2, bus.d1, bus.d0};
    endfunction

    initial begin
        logic [4*N-1:0] t;
        t = TXT;
        for (int i = 0; i < N; i++) txt_nib[i] = t[4*(N-1-i) +: 4];
        m_saved = 1;
        reset = 1'b0; bus.step = 1'b0; bus.run_req = 1'b0; bus.dir = 1'b0; bus.reload = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b1;

        // Reset state, steps ignored while idle
        chk("rst_win", win(), 16'hAAA3);
        chk("rst_blank", bus.blank, 4'b1110);
        chk("rst_state", bus.state, 0);
        steps(3);
        chk("idle_win", win(), 16'hAAA3);
        chk("idle_state", bus.state, 0);

        // Left scroll, full revolution
        bus.run_req = 1'b1;
        tick();
        chk("hold_state", bus.state, 1);
        steps(4);
        chk("scroll_state", bus.state, 2);
        steps(1);
        chk("left1_win", win(), 16'hAA32);
        chk("left1_blank", bus.blank, 4'b1100);
        steps(10);
        chk("wrapL", bus.wrap, 1);
        chk("wrapL_win", win(), 16'hAAA3);
        chk("wrapL_state", bus.state, 1);
        tick();
        chk("wrapL_pulse", bus.wrap, 0);

        // Right scroll revolution
        steps(4);
        bus.dir = 1'b1;
        steps(1);
        chk("right1_win", win(), 16'h8AAA);
        chk("right1_blank", bus.blank, 4'b0111);
        chk("right1_pos", bus.pos, 10);
        steps(10);
        chk("wrapR", bus.wrap, 1);

        // Pause with a dropped step and blinking
        bus.dir = 1'b0;
        steps(4);
        steps(3);
        bus.run_req = 1'b0;
        steps(1);
        chk("pause_state", bus.state, 3);
        chk("pause_pos", bus.pos, 3);
        steps(1);
        chk("blink_on", bus.blank, 4'hF);
        steps(1);
        chk("blink_off", bus.blank, 4'h0);
        bus.run_req = 1'b1;
        tick();
        chk("resume_state", bus.state, 2);
        steps(1);
        chk("resume_pos", bus.pos, 4);

        // Reload beats a coincident step
        steps(2);
        bus.reload = 1'b1;
        bus.step   = 1'b1;
        tick();
        chk("reload_win", win(), 16'hAAA3);
        chk("reload_pos", bus.pos, 0);
        chk("reload_state", bus.state, 1);
        chk("reload_wrap", bus.wrap, 0);
        steps(3);
        chk("redwell_state", bus.state, 1);
        steps(1);
        chk("redwell_done", bus.state, 2);

        // Reset while paused with blink lit
        steps(2);
        bus.run_req = 1'b0;
        tick();
        steps(1);
        chk("pre_rst_blank", bus.blank, 4'hF);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("prst_state", bus.state, 0);
        chk("prst_blank", bus.blank, 4'b1110);
        chk("prst_win", win(), 16'hAAA3);

        // Reload with run_req low lands in IDLE
        bus.run_req = 1'b1;
        tick();
        bus.run_req = 1'b0;
        tick();
        bus.reload = 1'b1;
        tick();
        chk("reload_idle", bus.state, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
